tcm_port_arbiter: RTL
=====================

# tcm_port_arbiter

Shares one port of the dual-port TCM scratchpad SRAM between two requesters: requester 0 is the core data path, requester 1 is the debug/DMA loader. Each cycle it selects one request, forwards it to the SRAM port, and routes the one-cycle-later read data and ready back to the requester that issued it. A bounded lock lets one requester hold the port for back-to-back accesses.

## Interface
- DATA_WIDTH, 32: SRAM word width in bits; a multiple of 8.
- N_ENTRIES, 1024: SRAM depth; address width AW = $clog2(N_ENTRIES).
- LOCK_MAX, 8: maximum consecutive locked grants before the owner is forced to yield; must be ≥ 1.
- clk_i  in  1  single clock for the block and the SRAM port.
- rst_i  in  1  synchronous reset, active-high.
- mN_req_i (N=0,1)  in  1  access request; held high until granted.
- mN_lock_i  in  1  keep ownership for the next access.
- mN_we_i  in  1  1 = write, 0 = read.
- mN_be_i  in  DATA_WIDTH/8  byte enables for writes.
- mN_addr_i  in  AW  word address.
- mN_data_i  in  DATA_WIDTH  write data.
- mN_gnt_o  out  1  request accepted this cycle (combinational).
- mN_data_o  out  DATA_WIDTH  read data, valid while mN_ready_o = 1.
- mN_ready_o  out  1  access completed; one-cycle pulse.
- sram_en_o  out  1  SRAM port enable.
- sram_we_o  out  1  SRAM write enable.
- sram_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- sram_addr_o  out  AW  SRAM address.
- sram_data_o  out  DATA_WIDTH  SRAM write data.
- sram_data_i  in  DATA_WIDTH  SRAM read data, one cycle after enable.
- sram_ready_i  in  1  SRAM ready, one cycle after enable.

## Operation
- Grant selection in cycle T:
  - If the lock owner is valid and its request is high, the owner wins, unless the lock count has reached LOCK_MAX and the other requester is requesting.
  - Otherwise, if exactly one requester is requesting, that requester wins.
  - If both are requesting, the arbitration policy decides (see Configuration).
- SRAM port mux: sram_* carry the winner's fields. sram_en_o = winner valid and !rst_i. With no winner, all sram_* outputs are 0.
- Response tracking:
  - Registered state `resp_owner` (1 bit) and `resp_valid` record who was granted in cycle T.
  - In T+1: mN_ready_o = sram_ready_i & resp_valid & (resp_owner == N), and mN_data_o = sram_data_i.
  - The non-owner's ready is 0 and its data is 0.
- Writes also return a ready pulse; mN_data_o is don't-care for writes.
- Lock state: registers `lock_valid`, `lock_owner`, and `lock_cnt` (width $clog2(LOCK_MAX+1)).
  - On a grant with lock_i = 1: lock_valid ← 1, lock_owner ← winner, lock_cnt ← lock_cnt + 1 if the same owner, else 1.
  - On a grant with lock_i = 0, or a forced yield: lock_valid ← 0, lock_cnt ← 0.
  - If the owner drops req_i while locked, the lock is released in that cycle.
- Pipelining: one new grant per cycle. A new grant in T+1 is legal while the T response returns.

## Timing
- Grant to SRAM: 0 cycles (combinational path req → gnt/sram_*).
- Grant to mN_ready_o: exactly 1 cycle.
- Reset values:
  - all mN_gnt_o, mN_ready_o, and sram_en_o = 0;
  - mN_data_o = 0;
  - resp_valid = 0, lock_valid = 0, lock_cnt = 0, rr_last = 1 (requester 0 is favoured first).
- Reset asserted mid-access: grants are suppressed in the reset cycle, and a response due in the cycle after reset is dropped (resp_valid cleared).
- Simultaneous lock expiry and a new request from the other requester: the other requester wins that same cycle.
- lock_cnt saturates at LOCK_MAX; it never wraps.

## Configuration
- TCM_ARB_RR_EN defined: round-robin policy. Register `rr_last` records the last winner; on contention the requester ≠ rr_last wins. rr_last updates on every grant.
- TCM_ARB_RR_EN undefined: fixed priority, requester 0 always wins contention. rr_last is not implemented. The lock and its LOCK_MAX forced yield still apply in both builds.

## Structure
- Shared package `tcm_pkg`:
  - localparam for the default LOCK_MAX;
  - typedef `tcm_req_t` bundling we/be/addr/data;
  - enum for requester IDs (REQ_CORE = 0, REQ_DBG = 1).
- One natural sub-module: `tcm_arb_pick`, a purely combinational winner selection (inputs: reqs, lock state, rr_last; output: winner id and valid). The top level holds the mux, lock, and response registers.

## Test plan
- Single read: m0 reads addr 5 (RAM[5] = 0xDEADBEEF) → m0_gnt_o = 1 in T, m0_ready_o = 1 with data 0xDEADBEEF in T+1, m1_ready_o = 0.
- Contention: m0 and m1 both request every cycle.
  - RR build: grants alternate 0,1,0,1.
  - Fixed build: m0 is granted every cycle and m1 never.
- Byte write: m1 writes be = 4'b0010, data 0x0000AB00 to addr 3, then m0 reads addr 3 → byte 1 = 0xAB, other bytes unchanged.
- Lock limit: LOCK_MAX = 8, m1 holds lock_i = 1 and req_i = 1 while m0 requests → m1 gets 8 consecutive grants, m0 is granted on the 9th cycle, and lock_cnt returns to 0.
- Back-to-back: m0 reads addr 1, 2, 3 on consecutive cycles → ready pulses on 3 consecutive cycles carrying RAM[1..3] in order.
- Reset mid-access: grant m0 read in T, assert rst_i in T+1 → m0_ready_o = 0 in T+1 and T+2, and after reset m0 wins first on contention.

Source files
------------

// File: rtl/tcm_port_arbiter_pkg.sv
// Shared types and defaults for the TCM port arbiter.
package tcm_pkg;

    localparam int unsigned TCM_DATA_WIDTH = 32;
    localparam int unsigned TCM_N_ENTRIES  = 1024;
    localparam int unsigned TCM_LOCK_MAX   = 8;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    // Request fields at the default geometry.
    typedef struct packed {
        logic                            we;
        logic [TCM_DATA_WIDTH/8-1:0]     be;
        logic [$clog2(TCM_N_ENTRIES)-1:0] addr;
        logic [TCM_DATA_WIDTH-1:0]       data;
    } tcm_req_t;

endpackage

// File: rtl/tcm_port_arbiter_if.sv
// Requester and SRAM-side signals of the TCM port arbiter.
interface tcm_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_ENTRIES  = 1024
);
    localparam int unsigned AW = $clog2(N_ENTRIES);
    localparam int unsigned BW = DATA_WIDTH / 8;

    logic                  m0_req_i, m0_lock_i, m0_we_i;
    logic [BW-1:0]         m0_be_i;
    logic [AW-1:0]         m0_addr_i;
    logic [DATA_WIDTH-1:0] m0_data_i;
    logic                  m0_gnt_o, m0_ready_o;
    logic [DATA_WIDTH-1:0] m0_data_o;

    logic                  m1_req_i, m1_lock_i, m1_we_i;
    logic [BW-1:0]         m1_be_i;
    logic [AW-1:0]         m1_addr_i;
    logic [DATA_WIDTH-1:0] m1_data_i;
    logic                  m1_gnt_o, m1_ready_o;
    logic [DATA_WIDTH-1:0] m1_data_o;

    logic                  sram_en_o, sram_we_o;
    logic [BW-1:0]         sram_be_o;
    logic [AW-1:0]         sram_addr_o;
    logic [DATA_WIDTH-1:0] sram_data_o;
    logic [DATA_WIDTH-1:0] sram_data_i;
    logic                  sram_ready_i;

    modport slave (
        input  m0_req_i, m0_lock_i, m0_we_i, m0_be_i, m0_addr_i, m0_data_i,
        output m0_gnt_o, m0_ready_o, m0_data_o,
        input  m1_req_i, m1_lock_i, m1_we_i, m1_be_i, m1_addr_i, m1_data_i,
        output m1_gnt_o, m1_ready_o, m1_data_o,
        output sram_en_o, sram_we_o, sram_be_o, sram_addr_o, sram_data_o,
        input  sram_data_i, sram_ready_i
    );

    modport master (
        output m0_req_i, m0_lock_i, m0_we_i, m0_be_i, m0_addr_i, m0_data_i,
        input  m0_gnt_o, m0_ready_o, m0_data_o,
        output m1_req_i, m1_lock_i, m1_we_i, m1_be_i, m1_addr_i, m1_data_i,
        input  m1_gnt_o, m1_ready_o, m1_data_o,
        input  sram_en_o, sram_we_o, sram_be_o, sram_addr_o, sram_data_o,
        output sram_data_i, sram_ready_i
    );

endinterface

// File: rtl/tcm_port_arbiter_pick.sv
// Combinational winner selection. TCM_ARB_RR_EN selects round-robin
// contention; otherwise requester 0 has fixed priority.
module tcm_arb_pick
    import tcm_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lock_valid,
    input  req_id_e    lock_owner,
    input  logic       lock_at_max,
`ifdef TCM_ARB_RR_EN
    input  req_id_e    rr_last,
`endif
    output req_id_e    win_id,
    output logic       win_valid
);
    req_id_e other;

    always_comb begin
        other     = req_id_e'(~lock_owner);
        win_id    = REQ_CORE;
        win_valid = |req;
        // An exhausted lock hands the port to a waiting requester in the same cycle.
        if (lock_valid && req[lock_owner] && !(lock_at_max && req[other])) begin
            win_id = lock_owner;
        end else if (lock_valid && lock_at_max && req[other]) begin
            win_id = other;
        end else if (req == 2'b10) begin
            win_id = REQ_DBG;
        end else if (req == 2'b11) begin
`ifdef TCM_ARB_RR_EN
            win_id = req_id_e'(~rr_last);
`else
            win_id = REQ_CORE;
`endif
        end
    end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Two-requester arbiter for one TCM SRAM port with bounded lock and
// one-cycle response routing. Policy macro: TCM_ARB_RR_EN.
module tcm_port_arbiter
    import tcm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TCM_DATA_WIDTH,
    parameter int unsigned N_ENTRIES  = TCM_N_ENTRIES,
    parameter int unsigned LOCK_MAX   = TCM_LOCK_MAX
) (
    input logic               clk_i,
    input logic               rst_i,
    tcm_port_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(N_ENTRIES);
    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    typedef struct packed {
        logic                  we;
        logic [BW-1:0]         be;
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } port_req_t;

    logic          lock_valid_q, lock_valid_d;
    req_id_e       lock_owner_q, lock_owner_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          resp_valid_q, resp_valid_d;
    req_id_e       resp_owner_q, resp_owner_d;
`ifdef TCM_ARB_RR_EN
    req_id_e       rr_last_q, rr_last_d;
`endif

    logic [1:0] req;
    logic       lock_at_max, win_valid, win_lock, hit0, hit1;
    req_id_e    win_id;
    port_req_t  sel;

    assign req         = {bus.m1_req_i, bus.m0_req_i} & {2{~rst_i}};
    assign lock_at_max = (lock_cnt_q == CW'(LOCK_MAX));

    tcm_arb_pick u_pick (
        .req         (req),
        .lock_valid  (lock_valid_q),
        .lock_owner  (lock_owner_q),
        .lock_at_max (lock_at_max),
`ifdef TCM_ARB_RR_EN
        .rr_last     (rr_last_q),
`endif
        .win_id      (win_id),
        .win_valid   (win_valid)
    );

    always_comb begin
        sel      = '0;
        win_lock = 1'b0;
        if (win_valid) begin
            if (win_id == REQ_DBG) begin
                sel      = '{bus.m1_we_i, bus.m1_be_i, bus.m1_addr_i, bus.m1_data_i};
                win_lock = bus.m1_lock_i;
            end else begin
                sel      = '{bus.m0_we_i, bus.m0_be_i, bus.m0_addr_i, bus.m0_data_i};
                win_lock = bus.m0_lock_i;
            end
        end
        bus.m0_gnt_o    = win_valid && (win_id == REQ_CORE);
        bus.m1_gnt_o    = win_valid && (win_id == REQ_DBG);
        bus.sram_en_o   = win_valid;
        bus.sram_we_o   = sel.we;
        bus.sram_be_o   = sel.be;
        bus.sram_addr_o = sel.addr;
        bus.sram_data_o = sel.data;
    end

    // A response landing while reset is asserted is dropped.
    always_comb begin
        hit0           = resp_valid_q && !rst_i && (resp_owner_q == REQ_CORE);
        hit1           = resp_valid_q && !rst_i && (resp_owner_q == REQ_DBG);
        bus.m0_ready_o = bus.sram_ready_i && hit0;
        bus.m1_ready_o = bus.sram_ready_i && hit1;
        bus.m0_data_o  = hit0 ? bus.sram_data_i : '0;
        bus.m1_data_o  = hit1 ? bus.sram_data_i : '0;
    end

    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        resp_valid_d = win_valid;
        resp_owner_d = win_id;
`ifdef TCM_ARB_RR_EN
        rr_last_d    = win_valid ? win_id : rr_last_q;
`endif
        if (win_valid && win_lock) begin
            lock_valid_d = 1'b1;
            lock_owner_d = win_id;
            if (lock_valid_q && (lock_owner_q == win_id))
                lock_cnt_d = lock_at_max ? lock_cnt_q : lock_cnt_q + CW'(1);
            else
                lock_cnt_d = CW'(1);
        end else if (win_valid || lock_valid_q) begin
            // Unlocked grant, forced yield, or owner dropped its request.
            lock_valid_d = 1'b0;
            lock_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= REQ_CORE;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= REQ_CORE;
`ifdef TCM_ARB_RR_EN
            rr_last_q    <= REQ_DBG;
`endif
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
`ifdef TCM_ARB_RR_EN
            rr_last_q    <= rr_last_d;
`endif
        end
    end

endmodule
